// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared state encoding and default widths for pipe_stage_reg.
// Revision : 1.0
// ============================================================================
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_TWO   = 2'd2
    } pipe_state_t;

    localparam int PIPE_DATA_W = 96;
    localparam int PIPE_CTRL_W = 8;
    localparam int PIPE_CNT_W  = 16;

endpackage
`default_nettype wire

// File: rtl/pipe_stall_counter.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stall_counter
// Purpose  : Saturating event counter with synchronous clear (clear wins).
// Revision : 1.0
// ============================================================================
module pipe_stall_counter
    import pipe_pkg::*;
#(
    parameter int CNT_W = PIPE_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_sat;

    assign w_sat = (r_cnt == {CNT_W{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !w_sat) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Valid/ready pipeline-stage register with flush, bubble-zeroed
//            control and stall counter. Define PIPE_SKID_EN for a skid entry.
// Revision : 1.0
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int CNT_W  = PIPE_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    pipe_state_t       r_state;
    pipe_state_t       w_state_nxt;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic              w_in_hs;
    logic              w_out_hs;
    logic              w_load_in;
`ifdef PIPE_SKID_EN
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic              r_in_ready;
    logic              w_load_skid;
    logic              w_skid_to_main;
`endif

    assign w_in_hs  = in_valid && in_ready;
    assign w_out_hs = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= PS_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_in   = 1'b0;
`ifdef PIPE_SKID_EN
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
`endif
        if (flush) begin
            w_state_nxt = PS_EMPTY;
        end else begin
            case (r_state)
                PS_EMPTY: begin
                    if (w_in_hs) begin
                        w_state_nxt = PS_ONE;
                        w_load_in   = 1'b1;
                    end
                end
                PS_ONE: begin
                    if (w_in_hs && w_out_hs) begin
                        w_load_in = 1'b1;
                    end else if (w_out_hs) begin
                        w_state_nxt = PS_EMPTY;
`ifdef PIPE_SKID_EN
                    end else if (w_in_hs) begin
                        w_state_nxt = PS_TWO;
                        w_load_skid = 1'b1;
`endif
                    end
                end
`ifdef PIPE_SKID_EN
                PS_TWO: begin
                    if (w_out_hs) begin
                        w_state_nxt    = PS_ONE;
                        w_skid_to_main = 1'b1;
                    end
                end
`endif
                default: w_state_nxt = PS_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main_data <= '0;
            r_main_ctrl <= '0;
        end else if (w_load_in) begin
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
`ifdef PIPE_SKID_EN
        end else if (w_skid_to_main) begin
            r_main_data <= r_skid_data;
            r_main_ctrl <= r_skid_ctrl;
`endif
        end
    end

`ifdef PIPE_SKID_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else if (w_load_skid) begin
            r_skid_data <= in_data;
            r_skid_ctrl <= in_ctrl;
        end
    end

    // Registered ready: depends only on the next state, never on out_ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_ready <= 1'b1;
        end else begin
            r_in_ready <= (w_state_nxt != PS_TWO);
        end
    end

    assign in_ready = r_in_ready;
`else
    assign in_ready = !out_valid || out_ready;
`endif

    assign out_valid = (r_state != PS_EMPTY);
    assign out_data  = r_main_data;
    assign out_ctrl  = out_valid ? r_main_ctrl : '0;

    pipe_stall_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (reset),
        .i_clr (clr_cnt),
        .i_inc (out_valid && !out_ready),
        .o_cnt (stall_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Purpose  : Randomised self-checking bench against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_pipe_stage_reg;

    localparam int DW  = 96;
    localparam int CW  = 8;
    localparam int VW  = 39;
`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          clr_cnt = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          in_ready, out_valid, in_ready3, out_valid3;
    logic [DW-1:0] out_data, out_data3;
    logic [CW-1:0] out_ctrl, out_ctrl3;
    logic [15:0]   stall_cnt;
    logic [2:0]    stall_cnt3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .clr_cnt(clr_cnt), .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(3)) u_dut3 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3), .out_ctrl(out_ctrl3),
        .clr_cnt(clr_cnt), .stall_cnt(stall_cnt3)
    );

    // Reference model: a FIFO of capacity 2 (skid) or 1 with pass-through.
    ent_t        mq[$];
    int unsigned m_stalls = 0;
    bit          m_ih, m_oh;

    function automatic bit exp_in_ready();
        if (SKID) return mq.size() < 2;
        return (mq.size() == 0) || out_ready;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_stalls = 0;
        end else begin
            m_ih = in_valid && exp_in_ready();
            m_oh = (mq.size() > 0) && out_ready;
            if (clr_cnt) m_stalls = 0;
            else if (mq.size() > 0 && !out_ready) m_stalls++;
            if (flush) begin
                mq.delete();
            end else begin
                if (m_oh) void'(mq.pop_front());
                if (m_ih) mq.push_back('{d: in_data, c: in_ctrl});
            end
        end
    end

    function automatic logic [VW-1:0] exp_vec();
        logic          v;
        logic [CW-1:0] c;
        logic [15:0]   e16;
        logic [2:0]    e3;
        v   = mq.size() > 0;
        c   = v ? mq[0].c : '0;
        e16 = (m_stalls > 65535) ? 16'hFFFF : m_stalls[15:0];
        e3  = (m_stalls > 7) ? 3'd7 : m_stalls[2:0];
        return {v, c, exp_in_ready(), e16, e3, v, c, exp_in_ready()};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {out_valid, out_ctrl, in_ready, stall_cnt, stall_cnt3,
                out_valid3, out_ctrl3, in_ready3};
    endfunction

    task automatic do_flush();
        flush = 1'b1; in_valid = 1'b0; clr_cnt = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        in_valid = 1'b1; in_data = 96'hDEAD; in_ctrl = 8'h3C; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (obs_vec() !== exp_vec())
            $display("FAIL reset_prep: got %h want %h", obs_vec(), exp_vec());
        if (obs_vec() !== exp_vec()) n_errors++;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, out_ctrl, stall_cnt, in_ready, out_valid3, stall_cnt3} !==
            {1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 3'd0}) begin
            $display("FAIL reset_async: got v=%b c=%h cnt=%0d rdy=%b v3=%b cnt3=%0d want v=0 c=00 cnt=0 rdy=1 v3=0 cnt3=0",
                     out_valid, out_ctrl, stall_cnt, in_ready, out_valid3, stall_cnt3);
            n_errors++;
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_stream();
        do_flush();
        out_ready = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            in_valid = (k < 8); in_data = DW'(k); in_ctrl = 8'hA5;
            @(negedge clk);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                $display("FAIL stream_model k=%0d: got %h want %h", k, obs_vec(), exp_vec());
                n_errors++;
            end
            if (k >= 1) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== DW'(k - 1) || out_ctrl !== 8'hA5 ||
                    (k < 8 && in_ready !== 1'b1)) begin
                    $display("FAIL stream_order k=%0d: got v=%b d=%0h c=%h rdy=%b want v=1 d=%0h c=a5 rdy=1",
                             k, out_valid, out_data, out_ctrl, in_ready, k - 1);
                    n_errors++;
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

`ifdef PIPE_SKID_EN
    task automatic test_backpressure();
        logic [DW-1:0] got[$];
        do_flush();
        in_valid = 1'b1; in_data = 96'd100; in_ctrl = 8'h11; out_ready = 1'b1;
        @(posedge clk); #1;
        in_data = 96'd101; in_ctrl = 8'h12; out_ready = 1'b0;
        @(posedge clk); #1;
        in_data = 96'd102; in_ctrl = 8'h13;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 96'd100 ||
                obs_vec() !== exp_vec()) begin
                $display("FAIL bp_hold i=%0d: got rdy=%b v=%b d=%0h want rdy=0 v=1 d=64", i, in_ready, out_valid, out_data);
                n_errors++;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                $display("FAIL bp_release i=%0d: got %h want %h", i, obs_vec(), exp_vec());
                n_errors++;
            end
            if (out_valid) got.push_back(out_data);
            if (in_valid && in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
        n_checks++;
        if (got.size() != 3 || got[0] !== 96'd100 || got[1] !== 96'd101 || got[2] !== 96'd102) begin
            $display("FAIL bp_order: got %0d entries want 3 in order 100,101,102", got.size());
            n_errors++;
        end
    endtask
`else
    task automatic test_noskid();
        do_flush();
        in_valid = 1'b1; in_data = 96'd200; in_ctrl = 8'h21; out_ready = 1'b0;
        @(posedge clk); #1;
        in_data = 96'd201; in_ctrl = 8'h22;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0 || out_data !== 96'd200) begin
            $display("FAIL noskid_full: got rdy=%b d=%0h want rdy=0 d=c8", in_ready, out_data);
            n_errors++;
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL noskid_comb_ready: got %b want 1", in_ready);
            n_errors++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 96'd201 || out_ctrl !== 8'h22 ||
            obs_vec() !== exp_vec()) begin
            $display("FAIL noskid_replace: got v=%b d=%0h c=%h want v=1 d=c9 c=22", out_valid, out_data, out_ctrl);
            n_errors++;
        end
        @(posedge clk); #1;
    endtask
`endif

    task automatic test_flush();
        do_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 96'd300; in_ctrl = 8'h31;
        @(posedge clk); #1;
        in_data = 96'd301; in_ctrl = 8'h32;
        @(posedge clk); #1;
        flush = 1'b1; in_data = 96'd302; in_ctrl = 8'h33;
        @(negedge clk);
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            $display("FAIL flush_pre: got %h want %h", obs_vec(), exp_vec());
            n_errors++;
        end
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || obs_vec() !== exp_vec()) begin
                $display("FAIL flush_empty i=%0d: got v=%b c=%h want v=0 c=00", i, out_valid, out_ctrl);
                n_errors++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_counter();
        do_flush();
        clr_cnt = 1'b1; in_valid = 1'b1; in_data = 96'd400; in_ctrl = 8'h44; out_ready = 1'b0;
        @(posedge clk); #1;
        clr_cnt = 1'b0; in_valid = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                $display("FAIL cnt_model i=%0d: got %h want %h", i, obs_vec(), exp_vec());
                n_errors++;
            end
            if (i == 6 || i == 11) begin
                n_checks++;
                if (stall_cnt !== 16'(i - 1) || stall_cnt3 !== ((i == 6) ? 3'd5 : 3'd7)) begin
                    $display("FAIL cnt_value i=%0d: got cnt=%0d cnt3=%0d want cnt=%0d cnt3=%0d",
                             i, stall_cnt, stall_cnt3, i - 1, (i == 6) ? 5 : 7);
                    n_errors++;
                end
            end
            @(posedge clk); #1;
        end
        clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        @(negedge clk);
        n_checks++;
        if (stall_cnt !== 16'd0 || stall_cnt3 !== 3'd0 || out_valid !== 1'b1) begin
            $display("FAIL cnt_clear: got cnt=%0d cnt3=%0d v=%b want cnt=0 cnt3=0 v=1", stall_cnt, stall_cnt3, out_valid);
            n_errors++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            clr_cnt   = ($urandom_range(0, 63) == 0);
            in_data   = {$urandom(), $urandom(), $urandom()};
            in_ctrl   = 8'($urandom());
            @(negedge clk);
            n_checks++;
            if (obs_vec() !== exp_vec() ||
                (mq.size() > 0 && (out_data !== mq[0].d || out_data3 !== mq[0].d))) begin
                $display("FAIL random i=%0d: got %h d=%h want %h", i, obs_vec(), out_data, exp_vec());
                n_errors++;
            end
            @(posedge clk); #1;
        end
        flush = 1'b0; clr_cnt = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        test_reset();
        test_stream();
`ifdef PIPE_SKID_EN
        test_backpressure();
`else
        test_noskid();
`endif
        test_flush();
        test_counter();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
